// File: rtl/bus_rr_scheduler.sv
// Round-robin owner of the shared bus: grants one pending driver port, pops one
// packet from it and pushes it to its unicast or broadcast destination(s).
module bus_rr_scheduler #(
    parameter int          pckg_sz = 16,
    parameter int          drvrs   = 8,
    parameter logic [7:0]  bcst_id = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
    output logic                            busy,
    output logic [7:0]                      grant_id,
    output logic [15:0]                     pkt_cnt,
    output logic [7:0]                      drop_cnt
);

    localparam int               IDX_W     = (drvrs > 2) ? $clog2(drvrs) : 1;
    localparam logic [7:0]       LAST_ID   = 8'(drvrs - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(drvrs - 1);
    localparam logic [7:0]       NUM_PORTS = 8'(drvrs);

    typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

    state_t             state_q, state_d;
    logic [7:0]         grant_q, grant_d;
    logic [pckg_sz-1:0] pkt_q, pkt_d;
    logic [15:0]        pkt_cnt_q, pkt_cnt_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   dest_idx;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   win_idx;
    logic               found;
    logic [7:0]         dest;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign grant_idx = grant_q[IDX_W-1:0];
    assign dest      = pkt_q[pckg_sz-1 -: 8];
    assign dest_idx  = dest[IDX_W-1:0];

    // Walk upward from the port after the last grant, wrapping, so the last
    // granted port is considered only after every other port.
    always_comb begin
        scan_idx = grant_idx;
        win_idx  = grant_idx;
        found    = 1'b0;
        for (int i = 0; i < drvrs; i++) begin
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
            if (!found && pndng[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        pkt_d      = pkt_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        pop        = '0;
        push       = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = 8'(win_idx);
                    state_d = POP;
                end
            end
            POP: begin
                // A source that withdrew keeps its grant so rotation moves past it.
                if (pndng[grant_idx]) begin
                    pop[grant_idx] = 1'b1;
                    pkt_d          = D_pop[grant_idx];
                    state_d        = PUSH;
                end else begin
                    state_d = IDLE;
                end
            end
            PUSH: begin
                state_d = IDLE;
                if (dest < NUM_PORTS) begin
                    push[dest_idx] = 1'b1;
                    pkt_cnt_d      = pkt_cnt_q + 16'd1;
                end else if (dest == bcst_id) begin
                    push            = '1;
                    push[grant_idx] = 1'b0;
                    pkt_cnt_d       = pkt_cnt_q + 16'd1;
                end else begin
                    drop_cnt_d = sat_inc8(drop_cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= LAST_ID;
            pkt_q      <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            pkt_q      <= pkt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign D_push   = {drvrs{pkt_q}};
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed bench for bus_rr_scheduler: expected pushes are queued when a packet
// is offered and compared when the scheduler drives the bus.
module tb_bus_rr_scheduler;

    localparam int N = 8;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        pndng;
    logic [N-1:0][W-1:0] d_pop;
    logic [N-1:0]        pop;
    logic [N-1:0]        push;
    logic [N-1:0][W-1:0] d_push;
    logic                busy;
    logic [7:0]          grant_id;
    logic [15:0]         pkt_cnt;
    logic [7:0]          drop_cnt;

    typedef struct packed {
        logic [7:0]  push;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_pkt;
    logic [7:0]  exp_drop;
    int          viol;
    logic [N-1:0] prev_pop;

    always #5 clk = ~clk;

    bus_rr_scheduler #(.pckg_sz(W), .drvrs(N), .bcst_id(8'hFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (d_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (d_push),
        .busy     (busy),
        .grant_id (grant_id),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pop(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (pop == '0 && n < 8);
        chk({tag, "_lat"}, 32'(n), 32'd1);
        chk(tag, 32'(pop), 32'(exp));
    endtask

    task automatic wait_push(input string tag);
        int   n;
        exp_t e;
        n = 0;
        do begin
            tick();
            n++;
        end while (push == '0 && n < 8);
        chk({tag, "_lat"}, 32'(n), 32'd1);
        e = '0;
        if (sb.size() != 0) e = sb.pop_front();
        chk({tag, "_vec"}, 32'(push), 32'(e.push));
        chk({tag, "_d0"}, 32'(d_push[0]), 32'(e.data));
        chk({tag, "_d7"}, 32'(d_push[7]), 32'(e.data));
        chk({tag, "_nopop"}, 32'(pop), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        pndng    = '0;
        d_pop    = '0;
        exp_pkt  = '0;
        exp_drop = '0;
        #3 reset = 1'b0;
        pndng = 8'($urandom);
        repeat (3) tick();
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd7);
        chk("rst_pkt", 32'(pkt_cnt), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_dpush", 32'(d_push[3]), 32'd0);
        reset = 1'b1;
        pndng = '0;
        tick();
        chk("rel_grant", 32'(grant_id), 32'd7);

        // Unicast 3 -> 5
        d_pop[3] = 16'h05AB;
        pndng    = 8'h08;
        sb.push_back('{8'h20, 16'h05AB});
        wait_pop("uni_pop", 8'h08);
        chk("uni_grant", 32'(grant_id), 32'd3);
        chk("uni_busy", 32'(busy), 32'd1);
        wait_push("uni_push");
        pndng = '0;
        exp_pkt++;
        tick();
        chk("uni_idle", 32'(busy), 32'd0);
        chk("uni_push_off", 32'(push), 32'd0);
        chk("uni_pkt", 32'(pkt_cnt), 32'(exp_pkt));
        chk("uni_dhold", 32'(d_push[5]), 32'h05AB);

        // Round robin between ports 0 and 2
        d_pop[0] = 16'h0100;
        d_pop[2] = 16'h0300;
        pndng    = 8'h05;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                sb.push_back('{8'h02, 16'h0100});
                wait_pop("rr_pop", 8'h01);
                chk("rr_grant", 32'(grant_id), 32'd0);
            end else begin
                sb.push_back('{8'h08, 16'h0300});
                wait_pop("rr_pop", 8'h04);
                chk("rr_grant", 32'(grant_id), 32'd2);
            end
            wait_push("rr_push");
            exp_pkt++;
            if (i == 3) pndng = '0;
            tick();
        end
        chk("rr_pkt", 32'(pkt_cnt), 32'(exp_pkt));

        // Broadcast from port 1
        d_pop[1] = 16'hFF12;
        pndng    = 8'h02;
        sb.push_back('{8'hFD, 16'hFF12});
        wait_pop("bc_pop", 8'h02);
        chk("bc_grant", 32'(grant_id), 32'd1);
        wait_push("bc_push");
        pndng = '0;
        exp_pkt++;
        tick();
        chk("bc_pkt", 32'(pkt_cnt), 32'(exp_pkt));

        // Invalid destinations: 0x0A and 0x08 (one past the last port)
        for (int i = 0; i < 2; i++) begin
            d_pop[1] = (i == 0) ? 16'h0A00 : 16'h0800;
            pndng    = 8'h02;
            wait_pop("inv_pop", 8'h02);
            tick();
            chk("inv_push", 32'(push), 32'd0);
            chk("inv_dpush", 32'(d_push[4]), 32'(d_pop[1]));
            pndng = '0;
            exp_drop++;
            tick();
            chk("inv_drop", 32'(drop_cnt), 32'(exp_drop));
            chk("inv_pkt", 32'(pkt_cnt), 32'(exp_pkt));
        end

        // Self-addressed unicast from port 4
        d_pop[4] = 16'h0477;
        pndng    = 8'h10;
        sb.push_back('{8'h10, 16'h0477});
        wait_pop("self_pop", 8'h10);
        chk("self_grant", 32'(grant_id), 32'd4);
        wait_push("self_push");
        pndng = '0;
        exp_pkt++;
        tick();
        chk("self_pkt", 32'(pkt_cnt), 32'(exp_pkt));

        // Port 6 withdraws before its pop
        pndng = 8'h40;
        tick();
        pndng = '0;
        #1;
        chk("wd_pop", 32'(pop), 32'd0);
        chk("wd_busy", 32'(busy), 32'd1);
        chk("wd_grant", 32'(grant_id), 32'd6);
        tick();
        chk("wd_idle", 32'(busy), 32'd0);
        chk("wd_push", 32'(push), 32'd0);
        chk("wd_pkt", 32'(pkt_cnt), 32'(exp_pkt));
        chk("wd_drop", 32'(drop_cnt), 32'(exp_drop));
        chk("wd_grant2", 32'(grant_id), 32'd6);

        // Drop counter saturation, also watching pop/push exclusivity
        d_pop[1] = 16'h0A00;
        pndng    = 8'h02;
        viol     = 0;
        prev_pop = '0;
        for (int i = 0; i < 3 * 260; i++) begin
            tick();
            if (pop != '0 && push != '0) viol++;
            if (pop != '0 && prev_pop != '0) viol++;
            prev_pop = pop;
        end
        pndng = '0;
        repeat (4) tick();
        exp_drop = 8'hFF;
        chk("sat_viol", 32'(viol), 32'd0);
        chk("sat_drop", 32'(drop_cnt), 32'(exp_drop));
        chk("sat_pkt", 32'(pkt_cnt), 32'(exp_pkt));

        // Reset asserted during the PUSH cycle of a unicast 0 -> 2
        d_pop[0] = 16'h0200;
        pndng    = 8'h01;
        sb.push_back('{8'h04, 16'h0200});
        wait_pop("mid_pop", 8'h01);
        wait_push("mid_push");
        reset = 1'b0;
        #1;
        chk("mid_push_off", 32'(push), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_grant", 32'(grant_id), 32'd7);
        chk("mid_pkt", 32'(pkt_cnt), 32'd0);
        chk("mid_drop", 32'(drop_cnt), 32'd0);
        chk("mid_dpush", 32'(d_push[2]), 32'd0);
        exp_pkt  = '0;
        exp_drop = '0;
        pndng    = '0;
        tick();
        reset = 1'b1;
        pndng = 8'h05;
        sb.push_back('{8'h04, 16'h0200});
        wait_pop("post_pop", 8'h01);
        chk("post_grant", 32'(grant_id), 32'd0);
        chk("post_pkt0", 32'(pkt_cnt), 32'd0);
        wait_push("post_push");
        pndng = '0;
        exp_pkt++;
        tick();
        chk("post_pkt", 32'(pkt_cnt), 32'(exp_pkt));
        chk("post_drop", 32'(drop_cnt), 32'(exp_drop));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_rr_scheduler.md
Name: bus_rr_scheduler

Overview:
- Round-robin scheduler that owns the shared bus between `drvrs` FIFO-style driver ports: picks one pending source, pops one packet, pushes it to its destination port(s).
- Same `pndng`/`pop`/`push`/`D_pop`/`D_push` port contract as the existing bus generator/arbiter.
- Drop-in replacement DUT behind `dut_compl_if`; adds grant visibility and delivery/drop counters for the checker.

Parameters:
- `pckg_sz`, 16: packet width in bits; must be ≥ 9.
- `drvrs`, 8: number of driver ports; 2..255.
- `bcst_id`, 8'hFF: destination ID meaning broadcast.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pndng`  in  `drvrs`  per-port "FIFO head valid".
- `D_pop`  in  `drvrs` x `pckg_sz`  per-port FIFO head data.
- `pop`  out  `drvrs`  one-hot, one-cycle pop strobe to the source.
- `push`  out  `drvrs`  per-port push strobe to the destination(s).
- `D_push`  out  `drvrs` x `pckg_sz`  packet driven to every port (all copies identical).
- `busy`  out  1  high whenever the FSM is not IDLE.
- `grant_id`  out  8  index of the current/last granted source.
- `pkt_cnt`  out  16  delivered-packet counter; wraps at 16'hFFFF → 0.
- `drop_cnt`  out  8  dropped-packet counter; saturates at 8'hFF.

Behaviour:
- Reset (`reset`=0, asynchronous, any state):
  - state=IDLE; `pop`=0, `push`=0, `D_push`=0, `busy`=0.
  - `grant_id`=`drvrs`-1, so port 0 has first priority.
  - `pkt_cnt`=0, `drop_cnt`=0; latched packet cleared.
  - Release is synchronous to the next rising edge.
- Packet format: `dest` = `D_pop[pckg_sz-1 -: 8]`; the remaining bits are payload, never modified.
- FSM states: IDLE, POP, PUSH.
- IDLE:
  - If `pndng`≠0: winner = first set bit scanning upward from (`grant_id`+1) mod `drvrs`, wrapping.
  - Register winner into `grant_id`; go to POP.
  - Otherwise stay in IDLE.
- POP:
  - If `pndng[grant_id]`=1: assert `pop[grant_id]`=1 for exactly this cycle, latch `D_pop[grant_id]` at the cycle-ending edge, go to PUSH.
  - If `pndng[grant_id]`=0 (source withdrew): no pop, no count change, return to IDLE; `grant_id` keeps the withdrawn index, so rotation continues past it.
- PUSH (exactly one cycle), then always → IDLE. `D_push[k]` = latched packet for all k.
  - Unicast, `dest` < `drvrs`: `push[dest]`=1 only; `dest`==source is delivered. `pkt_cnt`+1.
  - Broadcast, `dest`==`bcst_id`: `push[k]`=1 for all k ≠ source. `pkt_cnt`+1 (one per packet, not per copy).
  - Invalid, otherwise: `push`=0, `drop_cnt`+1 unless already 8'hFF.
- Latency: `pndng` seen in IDLE at cycle N → `pop` at N+1 → `push` at N+2 → IDLE at N+3. Maximum throughput is 1 packet per 3 cycles.
- Fairness: with all ports pending continuously, each port is granted exactly once per `drvrs` grants.
- `pndng` changes while in PUSH are ignored until IDLE.
- `D_push` holds its last value outside PUSH; only `push` qualifies it.
- `pop` and `push` are never asserted in the same cycle.
- `pop` is never asserted for more than one cycle per grant.

Test Plan:
- Reset: hold `reset`=0 for 3 cycles with random `pndng` → `pop`=0, `push`=0, `busy`=0, `grant_id`=7, `pkt_cnt`=0, `drop_cnt`=0.
- Unicast: `pndng`=8'b0000_1000, `D_pop[3]`=16'h05AB, drop `pndng[3]` after the pop → `pop`=8'b0000_1000 at N+1; `push`=8'b0010_0000 at N+2; `D_push[5]`=16'h05AB; `pkt_cnt`=1; `grant_id`=3.
- Round robin: `pndng`=8'b0000_0101 held high for 12 cycles → grant sequence 0,2,0,2; `pkt_cnt`=4.
- Broadcast and invalid:
  - `D_pop[1]`=16'hFF12 → `push`=8'b1111_1101.
  - Then `D_pop[1]`=16'h0A00 → `pop[1]` pulses, `push` stays 0, `drop_cnt`=1, `pkt_cnt` unchanged.
- Withdraw: `pndng[6]` raised for 1 cycle only, then cleared → FSM goes IDLE→POP→IDLE; `pop`=0, no push, both counters unchanged, `grant_id`=6.
- Reset mid-transfer: assert `reset`=0 during PUSH cycle of a unicast to port 2 → `push` drops to 0 immediately (before next edge); `pkt_cnt`=0 after release; next grant goes to port 0.
